// File: rtl/tug_pkg.sv
// Shared constants and the 7-segment decoder for the tug-of-war game.
// Imported by the game top and its LFSR sub-module.
package tug_pkg;

    localparam int         WIN_SCORE  = 7;
    localparam int         LFSR_W     = 10;
    localparam logic [3:0] CENTER_POS = 4'd5;

    typedef enum logic {
        ST_PLAY,
        ST_OVER
    } game_state_t;

    // Active-low segment code, bit6..0 = g..a
    function automatic logic [6:0] seg7(input logic [2:0] v);
        logic [6:0] r;
        r = 7'b1111111;
        case (v)
            3'd0: r = 7'b1000000;
            3'd1: r = 7'b1111001;
            3'd2: r = 7'b0100100;
            3'd3: r = 7'b0110000;
            3'd4: r = 7'b0011001;
            3'd5: r = 7'b0010010;
            3'd6: r = 7'b0000010;
            3'd7: r = 7'b1111000;
            default: r = 7'b1111111;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tug_of_war_game_lfsr10.sv
// 10-bit XNOR LFSR driving the computer opponent.
// All-zeros is a legal state, so it starts from reset value 0.
module lfsr10
    import tug_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    // Shift left each cycle, feeding back the XNOR of taps 9 and 6
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= {q[8:0], ~(q[9] ^ q[6])};
        end
    end

endmodule

// File: rtl/tug_of_war_game.sv
// Tug-of-war board top: human button vs LFSR opponent on a 9-LED field.
// First side to WIN scores freezes the game until reset.
module tug_of_war_game
    import tug_pkg::*;
#(
    parameter int WIN = WIN_SCORE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic [8:0] SW,
    output logic [9:1] LED,
    output logic [6:0] HEX0,
    output logic [6:0] HEX4
);

    localparam logic [2:0] L_WIN = 3'(WIN);

    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic              r_c1;
    logic              r_c2;
    logic [3:0]        r_pos;
    logic [2:0]        r_hscore;
    logic [2:0]        r_cscore;
    game_state_t       r_state;

    logic [LFSR_W-1:0] w_q;
    logic              w_craw;
    logic              w_hp;
    logic              w_cp;
    logic [3:0]        w_pos_nxt;
    logic [2:0]        w_hscore_nxt;
    logic [2:0]        w_cscore_nxt;
    game_state_t       w_state_nxt;
    logic              w_unused;

    assign w_unused = ^key[3:1];

    lfsr10 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (w_q)
    );

    assign w_craw = ({1'b0, SW} > w_q);
    assign w_hp   = r_s2 & ~r_s3;
    assign w_cp   = r_c1 & ~r_c2;

    // Synchronize the key and register the computer compare for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
            r_c1 <= 1'b0;
            r_c2 <= 1'b0;
        end else begin
            r_s1 <= key[0];
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_c1 <= w_craw;
            r_c2 <= r_c1;
        end
    end

    // Game state register: position, both scores and play/over
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos    <= CENTER_POS;
            r_hscore <= 3'd0;
            r_cscore <= 3'd0;
            r_state  <= ST_PLAY;
        end else begin
            r_pos    <= w_pos_nxt;
            r_hscore <= w_hscore_nxt;
            r_cscore <= w_cscore_nxt;
            r_state  <= w_state_nxt;
        end
    end

    // Next-state: move toward the presser, score on push-off, stop at WIN
    always_comb begin
        w_pos_nxt    = r_pos;
        w_hscore_nxt = r_hscore;
        w_cscore_nxt = r_cscore;
        w_state_nxt  = r_state;
        if (r_state == ST_PLAY) begin
            if (w_hp && !w_cp) begin
                if (r_pos > 4'd1) begin
                    w_pos_nxt = r_pos - 4'd1;
                end else begin
                    w_pos_nxt    = CENTER_POS;
                    w_hscore_nxt = r_hscore + 3'd1;
                    if (w_hscore_nxt == L_WIN) begin
                        w_state_nxt = ST_OVER;
                    end
                end
            end else if (w_cp && !w_hp) begin
                if (r_pos < 4'd9) begin
                    w_pos_nxt = r_pos + 4'd1;
                end else begin
                    w_pos_nxt    = CENTER_POS;
                    w_cscore_nxt = r_cscore + 3'd1;
                    if (w_cscore_nxt == L_WIN) begin
                        w_state_nxt = ST_OVER;
                    end
                end
            end
        end
    end

    // One-hot playfield decode, dark once the game is over
    always_comb begin
        LED = '0;
        for (int i = 1; i <= 9; i++) begin
            LED[i] = (r_pos == 4'(i)) && (r_state == ST_PLAY);
        end
    end

    assign HEX0 = seg7(r_hscore);
    assign HEX4 = seg7(r_cscore);

endmodule

// File: tb/tb_tug_of_war_game.sv
// Directed bench for tug_of_war_game: reset, human scoring, held key,
// computer-only play against a reference LFSR, ties and mid-round reset.
module tb_tug_of_war_game;

    logic       clk;
    logic       reset;
    logic [3:0] key;
    logic [8:0] sw;
    logic [9:1] led;
    logic [6:0] hex0;
    logic [6:0] hex4;

    int tests;
    int failed;

    logic [6:0] seg_tab [0:7] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000
    };

    logic [9:1] LED_C = 9'b000010000;
    logic [6:0] H0    = 7'b1000000;

    // reference model state for the computer-only test
    logic [9:0] m_q;
    logic       m_c1;
    logic       m_c2;
    int         m_pos;
    int         m_cs;
    bit         m_over;

    tug_of_war_game dut (
        .clk  (clk),
        .reset(reset),
        .key  (key),
        .SW   (sw),
        .LED  (led),
        .HEX0 (hex0),
        .HEX4 (hex4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // one key pulse: high for one cycle, low for one cycle
    task automatic press();
        key[0] = 1'b1;
        step();
        key[0] = 1'b0;
        step();
    endtask

    task automatic model_edge();
        bit cp;
        bit craw;
        cp   = m_c1 & ~m_c2;
        craw = (int'(sw) > int'(m_q));
        m_q  = {m_q[8:0], ~(m_q[9] ^ m_q[6])};
        m_c2 = m_c1;
        m_c1 = craw;
        if (!m_over && cp) begin
            if (m_pos < 9) begin
                m_pos++;
            end else begin
                m_pos = 5;
                m_cs++;
                if (m_cs == 7) m_over = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key = 4'b0;
        sw = 9'd0;
        step();
        tests++;
        if (led !== LED_C) begin
            failed++;
            $display("FAIL reset_led got %b want %b", led, LED_C);
        end
        tests++;
        if (hex0 !== H0 || hex4 !== H0) begin
            failed++;
            $display("FAIL reset_hex got %b/%b want %b", hex0, hex4, H0);
        end
        step();
        reset = 1'b0;
        repeat (20) step();
        tests++;
        if (led !== LED_C) begin
            failed++;
            $display("FAIL idle_led got %b want %b", led, LED_C);
        end
        tests++;
        if (hex0 !== H0 || hex4 !== H0) begin
            failed++;
            $display("FAIL idle_hex got %b/%b want %b", hex0, hex4, H0);
        end
    endtask

    task automatic test_human_score();
        sw = 9'd0;
        key = 4'b0;
        do_reset();
        repeat (4) press();
        step();
        step();
        tests++;
        if (led !== 9'b000000001) begin
            failed++;
            $display("FAIL h4_led got %b want %b", led, 9'b000000001);
        end
        press();
        step();
        step();
        tests++;
        if (hex0 !== 7'b1111001) begin
            failed++;
            $display("FAIL h5_hex0 got %b want %b", hex0, 7'b1111001);
        end
        tests++;
        if (led !== LED_C) begin
            failed++;
            $display("FAIL h5_led got %b want %b", led, LED_C);
        end
        repeat (10) press();
        step();
        step();
        tests++;
        if (hex0 !== 7'b0110000) begin
            failed++;
            $display("FAIL h15_hex0 got %b want %b", hex0, 7'b0110000);
        end
        repeat (20) press();
        step();
        step();
        tests++;
        if (hex0 !== 7'b1111000) begin
            failed++;
            $display("FAIL win_hex0 got %b want %b", hex0, 7'b1111000);
        end
        tests++;
        if (led !== 9'b0) begin
            failed++;
            $display("FAIL win_led got %b want %b", led, 9'b0);
        end
        tests++;
        if (hex4 !== H0) begin
            failed++;
            $display("FAIL win_hex4 got %b want %b", hex4, H0);
        end
        repeat (10) press();
        step();
        step();
        tests++;
        if (led !== 9'b0 || hex0 !== 7'b1111000) begin
            failed++;
            $display("FAIL frozen got %b/%b want %b/%b",
                     led, hex0, 9'b0, 7'b1111000);
        end
    endtask

    task automatic test_hold();
        sw = 9'd0;
        key = 4'b0;
        do_reset();
        step();
        key[0] = 1'b1;
        step();
        step();
        tests++;
        if (led !== LED_C) begin
            failed++;
            $display("FAIL hold_early got %b want %b", led, LED_C);
        end
        step();
        tests++;
        if (led !== 9'b000001000) begin
            failed++;
            $display("FAIL hold_step got %b want %b", led, 9'b000001000);
        end
        repeat (50) step();
        tests++;
        if (led !== 9'b000001000) begin
            failed++;
            $display("FAIL hold_once got %b want %b", led, 9'b000001000);
        end
        key[0] = 1'b0;
    endtask

    task automatic test_computer();
        logic [9:1] exp;
        sw = 9'b111100000;
        key = 4'b0;
        do_reset();
        m_q = '0;
        m_c1 = 1'b0;
        m_c2 = 1'b0;
        m_pos = 5;
        m_cs = 0;
        m_over = 1'b0;
        for (int n = 0; n < 120; n++) begin
            step();
            model_edge();
            exp = '0;
            if (!m_over) exp[m_pos] = 1'b1;
            tests++;
            if (led !== exp) begin
                failed++;
                $display("FAIL cpu_led cyc %0d got %b want %b", n, led, exp);
            end
        end
        tests++;
        if (hex4 !== seg_tab[m_cs]) begin
            failed++;
            $display("FAIL cpu_hex4 got %b want %b", hex4, seg_tab[m_cs]);
        end
        tests++;
        if (hex4 === H0) begin
            failed++;
            $display("FAIL cpu_scored got %b want nonzero score", hex4);
        end
        tests++;
        if (hex0 !== H0) begin
            failed++;
            $display("FAIL cpu_hex0 got %b want %b", hex0, H0);
        end
    endtask

    // LFSR from reset: cp fires in the cycles after edge 1 and edge 18
    task automatic test_simultaneous();
        sw = 9'd511;
        key = 4'b0;
        do_reset();
        repeat (2) step();
        tests++;
        if (led !== 9'b000100000) begin
            failed++;
            $display("FAIL sim_pre got %b want %b", led, 9'b000100000);
        end
        repeat (14) step();
        key[0] = 1'b1;
        step();
        key[0] = 1'b0;
        step();
        step();
        tests++;
        if (led !== 9'b000100000) begin
            failed++;
            $display("FAIL sim_tie got %b want %b", led, 9'b000100000);
        end
        step();
        tests++;
        if (led !== 9'b000100000) begin
            failed++;
            $display("FAIL sim_after got %b want %b", led, 9'b000100000);
        end
    endtask

    task automatic test_mid_reset();
        sw = 9'd0;
        key = 4'b0;
        do_reset();
        repeat (15) press();
        repeat (2) press();
        step();
        step();
        tests++;
        if (hex0 !== 7'b0110000 || led !== 9'b000000100) begin
            failed++;
            $display("FAIL mid_pre got %b/%b want %b/%b",
                     hex0, led, 7'b0110000, 9'b000000100);
        end
        key[0] = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (led !== LED_C) begin
            failed++;
            $display("FAIL mid_async_led got %b want %b", led, LED_C);
        end
        tests++;
        if (hex0 !== H0 || hex4 !== H0) begin
            failed++;
            $display("FAIL mid_async_hex got %b/%b want %b", hex0, hex4, H0);
        end
        step();
        step();
        reset = 1'b0;
        step();
        step();
        tests++;
        if (led !== LED_C) begin
            failed++;
            $display("FAIL rel_early got %b want %b", led, LED_C);
        end
        step();
        tests++;
        if (led !== 9'b000001000) begin
            failed++;
            $display("FAIL rel_pulse got %b want %b", led, 9'b000001000);
        end
        repeat (5) step();
        tests++;
        if (led !== 9'b000001000) begin
            failed++;
            $display("FAIL rel_once got %b want %b", led, 9'b000001000);
        end
        key[0] = 1'b0;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        reset = 1'b1;
        key = 4'b0;
        sw = 9'd0;
        test_reset();
        test_human_score();
        test_hold();
        test_computer();
        test_simultaneous();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
